// File: rtl/rpn_stack_pkg.sv
// Shared definitions for the RPN evaluator: opcodes, FSM states and token helpers.
package rpn_stack_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_END = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_EXEC = 3'd2,
      S_SKIP = 3'd3,
      S_OUT  = 3'd4
   } state_e;

   function automatic logic op_is_arith(input logic [2:0] code);
      return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL);
   endfunction

   function automatic logic op_is_end(input logic [2:0] code);
      return code == OP_END;
   endfunction

endpackage

// File: rtl/lifo_stack.sv
// LIFO storage with top/second read ports; push, pop and pop-with-overwrite for binary ops.
module lifo_stack #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              wr_top,
   input  logic              clear,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] top,
   output logic [DATA_W-1:0] second,
   output logic              full,
   output logic              empty,
   output logic [PTR_W-1:0]  count
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  top_idx_s, sec_idx_s, wr_idx_s;
   logic              wr_en_s;

   assign top_idx_s = IDX_W'(ptr_q - PTR_W'(1));
   assign sec_idx_s = IDX_W'(ptr_q - PTR_W'(2));
   assign full      = (ptr_q == PTR_W'(DEPTH));
   assign empty     = (ptr_q == {PTR_W{1'b0}});
   assign count     = ptr_q;
   assign top       = empty ? {DATA_W{1'b0}} : mem_q[top_idx_s];
   assign second    = (ptr_q < PTR_W'(2)) ? {DATA_W{1'b0}} : mem_q[sec_idx_s];

   // Pointer update and write-port selection; a pop with wr_top replaces the new top in place.
   always_comb begin
      ptr_d    = ptr_q;
      wr_en_s  = 1'b0;
      wr_idx_s = top_idx_s;
      if (clear) begin
         ptr_d = {PTR_W{1'b0}};
      end else if (push && !full) begin
         wr_en_s  = 1'b1;
         wr_idx_s = IDX_W'(ptr_q);
         ptr_d    = ptr_q + PTR_W'(1);
      end else if (pop && !empty) begin
         ptr_d    = ptr_q - PTR_W'(1);
         wr_en_s  = wr_top;
         wr_idx_s = sec_idx_s;
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Stack pointer register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= {PTR_W{1'b0}};
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Storage array; contents need no reset because the pointer defines validity.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_idx_s] <= wr_data;
      end
   end

endmodule

// File: rtl/rpn_stack_eval.sv
// Postfix expression evaluator: token decode, control FSM, ALU and result registers
// around a lifo_stack. Malformed expressions end with err=1 and answer=0.
module rpn_stack_eval
   import rpn_stack_pkg::*;
#(
   parameter int TOKEN_W = 7,
   parameter int DATA_W  = 10,
   parameter int DEPTH   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [TOKEN_W-1:0]           variable,
   output logic                         req,
   output logic                         valid,
   output logic [DATA_W-1:0]            answer,
   output logic                         err,
   output logic [$clog2(DEPTH+1)-1:0]   depth
);
   localparam int PTR_W = $clog2(DEPTH + 1);

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [DATA_W-1:0] answer_q, answer_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] operand_s, alu_s, top_s, second_s, wr_data_s;
   logic [2:0]        code_s;
   logic              is_op_s, full_s, empty_s;
   logic              push_s, pop_s, wr_top_s, clear_s;
   logic [PTR_W-1:0]  count_s;

   assign is_op_s = variable[TOKEN_W-1];
   assign code_s  = variable[2:0];

   if (TOKEN_W - 1 >= DATA_W) begin : g_trunc
      assign operand_s = variable[DATA_W-1:0];
   end else begin : g_zext
      assign operand_s = {{(DATA_W - TOKEN_W + 1){1'b0}}, variable[TOKEN_W-2:0]};
   end

   lifo_stack #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_stack (
      .clk     (clk),
      .rst     (rst),
      .push    (push_s),
      .pop     (pop_s),
      .wr_top  (wr_top_s),
      .clear   (clear_s),
      .wr_data (wr_data_s),
      .top     (top_s),
      .second  (second_s),
      .full    (full_s),
      .empty   (empty_s),
      .count   (count_s)
   );

   // ALU: a = second-from-top, b = top; everything wraps modulo 2^DATA_W.
   always_comb begin
      alu_s = {DATA_W{1'b0}};
      case (op_q)
         OP_ADD:  alu_s = second_s + top_s;
         OP_SUB:  alu_s = second_s - top_s;
         OP_MUL:  alu_s = second_s * top_s;
         default: alu_s = {DATA_W{1'b0}};
      endcase
   end

   // Next-state logic and stack control.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      answer_d  = answer_q;
      err_d     = err_q;
      push_s    = 1'b0;
      pop_s     = 1'b0;
      wr_top_s  = 1'b0;
      clear_s   = 1'b0;
      wr_data_s = operand_s;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (!en) begin
               state_d = S_REQ;
            end else if (!is_op_s) begin
               if (full_s) begin
                  state_d = S_SKIP;
               end else begin
                  push_s = 1'b1;
               end
            end else if (op_is_end(code_s)) begin
               state_d = S_OUT;
               clear_s = 1'b1;
               if (count_s == PTR_W'(1)) begin
                  answer_d = top_s;
                  err_d    = 1'b0;
               end else begin
                  answer_d = {DATA_W{1'b0}};
                  err_d    = 1'b1;
               end
            end else if (!op_is_arith(code_s) || empty_s || count_s == PTR_W'(1)) begin
               state_d = S_SKIP;
            end else begin
               op_d    = code_s;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            pop_s     = 1'b1;
            wr_top_s  = 1'b1;
            wr_data_s = alu_s;
            state_d   = S_REQ;
         end
         S_SKIP: begin
            if (en && is_op_s && op_is_end(code_s)) begin
               state_d  = S_OUT;
               clear_s  = 1'b1;
               answer_d = {DATA_W{1'b0}};
               err_d    = 1'b1;
            end else begin
               state_d = S_SKIP;
            end
         end
         S_OUT:   state_d = S_REQ;
         default: state_d = S_IDLE;
      endcase
   end

   // State, latched opcode and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ADD;
         answer_q <= {DATA_W{1'b0}};
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         answer_q <= answer_d;
         err_q    <= err_d;
      end
   end

   assign req    = (state_q == S_REQ) || (state_q == S_SKIP);
   assign valid  = (state_q == S_OUT);
   assign answer = answer_q;
   assign err    = err_q;
   assign depth  = count_s;

endmodule

// File: tb/tb_rpn_stack_eval.sv
// Scoreboard bench for rpn_stack_eval: directed and random expressions checked
// against a queue-based postfix evaluator.
module tb_rpn_stack_eval;
   typedef logic [6:0] tok_t;
   typedef struct {
      logic [9:0] ans;
      logic       e;
   } exp_t;

   localparam tok_t T_ADD = 7'h40;
   localparam tok_t T_SUB = 7'h41;
   localparam tok_t T_MUL = 7'h42;
   localparam tok_t T_END = 7'h43;
   localparam tok_t T_ILL = 7'h45;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [6:0] variable = 7'd0;
   logic       req, valid, err;
   logic [9:0] answer;
   logic [4:0] depth;

   int   tests = 0;
   int   fails = 0;
   exp_t sbq[$];
   tok_t cur[$];

   always #5 clk = ~clk;

   rpn_stack_eval #(.TOKEN_W(7), .DATA_W(10), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .en(en), .variable(variable),
      .req(req), .valid(valid), .answer(answer), .err(err), .depth(depth)
   );

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: evaluate one expression with a plain integer stack.
   function automatic void model(input tok_t toks[$], output logic [9:0] ans, output logic e);
      int   st[$];
      int   a, b, r;
      bit   bad;
      tok_t t;
      bad = 1'b0;
      ans = 10'd0;
      e   = 1'b1;
      foreach (toks[i]) begin
         t = toks[i];
         if (t[6] && t[2:0] == 3'b011) begin
            if (!bad && st.size() == 1) begin
               ans = 10'(st[0]);
               e   = 1'b0;
            end
            return;
         end
         if (bad) continue;
         if (!t[6]) begin
            if (st.size() >= 16) bad = 1'b1;
            else st.push_back(int'(t[5:0]));
         end else if (t[2:0] <= 3'd2) begin
            if (st.size() < 2) begin
               bad = 1'b1;
            end else begin
               b = st.pop_back();
               a = st.pop_back();
               if (t[2:0] == 3'd0) r = a + b;
               else if (t[2:0] == 3'd1) r = a - b;
               else r = a * b;
               st.push_back(r & 1023);
            end
         end else begin
            bad = 1'b1;
         end
      end
   endfunction

   task automatic send(input tok_t t);
      int n;
      n = 0;
      @(negedge clk);
      while (!req && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!req) begin
         tests++;
         fails++;
         $display("FAIL req_timeout: req=%0b expected 1", req);
      end else begin
         en = 1'b1;
         variable = t;
         @(posedge clk);
         #1;
         en = 1'b0;
      end
   endtask

   task automatic run_expect(input logic [9:0] a, input logic e);
      exp_t x;
      x.ans = a;
      x.e   = e;
      sbq.push_back(x);
      foreach (cur[i]) send(cur[i]);
      cur.delete();
   endtask

   task automatic run_model();
      logic [9:0] a;
      logic       e;
      model(cur, a, e);
      run_expect(a, e);
   endtask

   task automatic random_exprs(input int n);
      int   cnt, len, r;
      tok_t t;
      for (int k = 0; k < n; k++) begin
         cnt = 0;
         len = $urandom_range(1, 12);
         for (int j = 0; j < len; j++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
               t = tok_t'($urandom_range(0, 127));
               if (t[6] && t[2:0] == 3'b011) t[2:0] = 3'b111;
            end else if (cnt < 2 || r < 50) begin
               t = {1'b0, 6'($urandom_range(0, 63))};
               cnt++;
            end else begin
               t = {4'b1000, 3'($urandom_range(0, 2))};
               cnt--;
            end
            cur.push_back(t);
         end
         if ($urandom_range(0, 9) != 0) begin
            while (cnt > 1) begin
               cur.push_back({4'b1000, 3'($urandom_range(0, 2))});
               cnt--;
            end
         end
         cur.push_back(T_END);
         run_model();
      end
   endtask

   // Monitor: every valid strobe must match the oldest expected result.
   always @(negedge clk) begin
      exp_t x;
      if (rst && valid) begin
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: answer=%0d err=%0b with no expected result", answer, err);
         end else begin
            x = sbq.pop_front();
            chk("answer", int'(answer), int'(x.ans));
            chk("err", int'(err), int'(x.e));
            chk("depth_at_valid", int'(depth), 0);
         end
      end
   end

   initial begin
      int n;
      #12;
      chk("rst_req", int'(req), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_answer", int'(answer), 0);
      chk("rst_depth", int'(depth), 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("idle_req", int'(req), 0);
      @(posedge clk);
      #1;
      chk("first_req", int'(req), 1);

      cur = '{7'd3, 7'd4, T_ADD, T_END};
      run_expect(10'd7, 1'b0);
      chk("depth_after_end", int'(depth), 0);

      sbq.push_back('{ans: 10'd28, e: 1'b0});
      send(7'd5);
      chk("push_req_high", int'(req), 1);
      send(7'd6);
      chk("push_req_high2", int'(req), 1);
      chk("depth_two", int'(depth), 2);
      send(T_MUL);
      chk("exec_req_low", int'(req), 0);
      chk("exec_depth_hold", int'(depth), 2);
      @(posedge clk);
      #1;
      chk("post_exec_req", int'(req), 1);
      chk("post_exec_depth", int'(depth), 1);
      send(7'd2);
      send(T_SUB);
      send(T_END);
      chk("end_valid", int'(valid), 1);
      chk("end_req_low", int'(req), 0);

      cur = '{7'd63, 7'd63, T_MUL, 7'd63, T_MUL, T_END};
      run_expect(10'd191, 1'b0);
      cur = '{7'd2, 7'd5, T_SUB, T_END};
      run_expect(10'd1021, 1'b0);

      for (int i = 0; i < 17; i++) cur.push_back(7'd1);
      cur.push_back(7'd1);
      cur.push_back(T_ADD);
      cur.push_back(T_END);
      run_expect(10'd0, 1'b1);
      cur = '{7'd1, 7'd1, T_ADD, T_END};
      run_expect(10'd2, 1'b0);

      cur = '{7'd3, T_ADD, T_END};
      run_expect(10'd0, 1'b1);
      cur = '{7'd1, 7'd2, T_END};
      run_expect(10'd0, 1'b1);
      cur = '{7'd1, T_ILL, T_END};
      run_expect(10'd0, 1'b1);

      send(7'd1);
      send(7'd2);
      send(7'd3);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_req", int'(req), 0);
      chk("midrst_valid", int'(valid), 0);
      chk("midrst_depth", int'(depth), 0);
      @(negedge clk);
      rst = 1'b1;

      sbq.push_back('{ans: 10'd9, e: 1'b0});
      send(7'd9);
      send(T_END);
      chk("valid_9", int'(valid), 1);
      en = 1'b1;
      variable = 7'd5;
      @(posedge clk);
      #1;
      en = 1'b0;
      chk("en_ignored_depth", int'(depth), 0);
      chk("valid_one_cycle", int'(valid), 0);
      cur = '{7'd4, 7'd5, T_MUL, T_END};
      run_expect(10'd20, 1'b0);

      random_exprs(40);

      n = 0;
      while (sbq.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: %0d results outstanding expected 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rpn_stack_eval.md
# rpn_stack_eval

Parametrised postfix (RPN) expression evaluator: the next generation of the team's stack block. It has the same req/en token-in and valid/answer result-out handshake. Token width, data width and stack depth are generic. It adds subtraction and multiplication, and flags malformed expressions (overflow, underflow, bad opcode, unbalanced end) instead of producing garbage. It sits between a token source and a result consumer, evaluating one expression after another.

## Interface

- `TOKEN_W`, default 7: token width; must be ≥ 4.
- `DATA_W`, default 10: operand, stack and result width.
- `DEPTH`, default 16: stack entries; must be ≥ 2.

- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- `en`  in  1  token strobe; honoured only in a cycle where `req`=1.
- `variable`  in  TOKEN_W  token.
- `req`  out  1  ready to accept a token this cycle.
- `valid`  out  1  one-cycle result strobe.
- `answer`  out  DATA_W  result; meaningful only while `valid`=1.
- `err`  out  1  expression error; meaningful only while `valid`=1.
- `depth`  out  $clog2(DEPTH+1)  current stack occupancy (debug).

## Operation

- Token decode:
  - MSB=0 → operand; value = low TOKEN_W-1 bits, zero-extended (or truncated) to DATA_W.
  - MSB=1 → operator, selected by the low 3 bits: 000 ADD, 001 SUB, 010 MUL, 011 END. Codes 100–111 are illegal.
- Binary operators pop b (top), then a, and push a op b.
  - SUB computes a−b.
  - All arithmetic is modulo 2^DATA_W (low DATA_W bits; MUL keeps the low DATA_W bits of the full product).
- END:
  - depth==1 → `answer`=top, `err`=0.
  - Otherwise → error.
- Error causes, each moving the FSM to S_SKIP:
  - operand pushed with depth==DEPTH (overflow);
  - operator with depth<2 (underflow);
  - illegal opcode.
- In S_SKIP, tokens are accepted and discarded until END, which yields `valid`=1, `err`=1, `answer`=0.
- END with depth≠1 yields the same error result directly.
- The stack is cleared to depth 0 after every END, whether or not an error occurred.
- FSM states and transitions:
  - S_IDLE: reset state → S_REQ.
  - S_REQ: operand → push, stay; operator → S_EXEC; END → S_OUT; error → S_SKIP.
  - S_EXEC: write result, depth−1 → S_REQ.
  - S_SKIP: END → S_OUT; any other token → stay.
  - S_OUT → S_REQ.

## Timing

- Reset values: state S_IDLE, `req`=0, `valid`=0, `err`=0, `answer`=0, `depth`=0. Stack contents are don't-care.
- `req`=1 exactly in S_REQ and S_SKIP; it is registered/decoded from state with no combinational path from `en`.
- First `req`=1 occurs in the first cycle after the first rising edge following `rst` release.
- Operand throughput: one per cycle, with `req` held high across back-to-back operands.
- Operator accepted at edge k: `req`=0 during cycle k→k+1, result visible in `depth` after k+1, `req`=1 again after k+1.
- END accepted at edge k: `valid`=1, `req`=0 for exactly cycle k→k+1; `answer` and `err` are stable in that cycle.
- `en` while `req`=0 is ignored with no side effects.
- `rst` low at any point, including mid-expression, mid-EXEC or during `valid`: all outputs go to reset values asynchronously and any partial expression is discarded.

## Structure

- Package `rpn_stack_pkg` holds:
  - opcode localparams (OP_ADD, OP_SUB, OP_MUL, OP_END);
  - state enum (S_IDLE, S_REQ, S_EXEC, S_SKIP, S_OUT);
  - token-field helper functions.
- Sub-module `lifo_stack`, parametrised DATA_W/DEPTH:
  - storage and pointer;
  - push/pop/clear;
  - top and second-from-top read ports;
  - full and empty flags;
  - asynchronous active-low reset of the pointer.
- The top level holds the FSM, decode, ALU and output registers.

## Test plan

- Reset, then 0000011, 0000100, 1000000, 1000011 (3 4 + END) → one `valid` pulse, `answer`=7, `err`=0, `depth`=0 afterwards.
- Back-to-back 5 6 * 2 − END → `answer`=28. `req` stays high across operand pushes and drops for one cycle per operator.
- Wrap-around with defaults: 63 63 * 63 * END → `answer`=191. Separately, 2 5 − END → `answer`=1021, `err`=0.
- Overflow: 17 operands then 1 + END → `valid` once, `err`=1, `answer`=0. Post-error tokens are discarded and the next expression 1 1 + END → 2.
- Error set, each giving `err`=1, `answer`=0:
  - 3 + END (underflow);
  - 1 2 END (unbalanced);
  - 1 1000101 END (illegal opcode).
- Reset mid-flight: push 3 operands, pull `rst` low between edges → `req`, `valid` and `depth` go to 0 immediately. After release, 9 END → `answer`=9. Also, `en` pulsed during the `valid` cycle is ignored.
